// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder
//               controller. Holds the controller state encoding and the
//               default operand width.
// Revision    : 1.0  Initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_fa_bit
// Description : Combinational one-bit full adder built from two half-adder
//               stages followed by an OR of the two partial carries.
// Ports       : x, y  - addend bits
//               ci    - carry in
//               s     - sum bit
//               co    - carry out
// Revision    : 1.0  Initial release
// ============================================================================
module serial_fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_h1_s;
    logic w_h1_c;
    logic w_h2_c;

    // First half adder: x + y
    assign w_h1_s = x ^ y;
    assign w_h1_c = x & y;

    // Second half adder: partial sum + carry in
    assign s      = w_h1_s ^ ci;
    assign w_h2_c = w_h1_s & ci;

    // At most one of the two partial carries can be set
    assign co     = w_h1_c | w_h2_c;

endmodule : serial_fa_bit
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Accepts two WIDTH-bit operands
//               plus carry-in over a valid/ready handshake, adds them one bit
//               per clock through a single full-adder slice, then presents
//               {cout,sum} over a second valid/ready handshake.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - operand handshake (ready only in IDLE)
//               a, b, cin          - operands and carry-in
//               out_valid/out_ready- result handshake (valid only in HOLD)
//               sum, cout          - registered result
//               busy               - high while bits are being added
// Revision    : 1.0  Initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int               CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s;
    logic               w_co;
    logic               w_last;

    // ------------------------------------------------------------------
    // Single full-adder slice operating on the LSBs of the shift registers
    // ------------------------------------------------------------------
    serial_fa_bit u_fa (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last = (r_cnt == C_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)  w_state_nxt = ADD;
            ADD:  if (w_last)    w_state_nxt = HOLD;
            HOLD: if (out_ready) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/sum shift registers, carry flop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // bit 0 of the result has arrived at bit 0.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    // Counter stops at the last bit rather than wrapping.
                    if (w_last) begin
                        r_cout <= w_co;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == ADD);
    assign out_valid = (r_state == HOLD);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire
